// File: rtl/mario_pkg.sv
// mario_pkg: shared state encoding, key codes and screen geometry for the player motion stage
package mario_pkg;
  typedef enum logic [1:0] {GROUND, RISE, FALL} motion_state_t;
  localparam logic [7:0] KEY_LEFT = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP = 8'h1A;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
endpackage

// File: rtl/mario_motion_if.sv
// mario_motion_if: collision-stage inputs and physics outputs of the player motion stage
interface mario_motion_if;
  logic frame_clk;
  logic [7:0] keycode;
  logic rightFlag, leftFlag, upFlag, downFlag;
  logic [9:0] collision_right, collision_left, collision_up, collision_down;
  logic [9:0] X_Pos, Y_Pos;
  logic [5:0] Right_V, Left_V, Up_V, Down_V;
  logic [20:0] logicalX;
  logic grounded;
  modport master (
    output frame_clk, keycode, rightFlag, leftFlag, upFlag, downFlag,
           collision_right, collision_left, collision_up, collision_down,
    input X_Pos, Y_Pos, Right_V, Left_V, Up_V, Down_V, logicalX, grounded
  );
  modport slave (
    input frame_clk, keycode, rightFlag, leftFlag, upFlag, downFlag,
          collision_right, collision_left, collision_up, collision_down,
    output X_Pos, Y_Pos, Right_V, Left_V, Up_V, Down_V, logicalX, grounded
  );
endinterface

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: 2-FF synchroniser on frame_clk plus a one-cycle rising-edge pulse
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic tick
);
  logic [2:0] s;
  // Reset to all ones so a frame_clk already high at reset release is not seen as an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= 3'b111;
    else s <= {s[1:0], d};
  assign tick = s[1] & ~s[2];
endmodule

// File: rtl/mario_motion.sv
// mario_motion: per-frame player physics (walk, scroll, jump/gravity FSM) after collision prediction
module mario_motion
  import mario_pkg::*;
#(
  parameter int X_START = 64,
  parameter int Y_START = 400,
  parameter int WALK_V = 2,
  parameter int JUMP_V = 12,
  parameter int GRAVITY = 1,
  parameter int MAX_FALL_V = 8,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int SCROLL_X = 320,
  parameter int LX_MAX = 2400
) (
  input logic Clk,
  input logic Reset,
  mario_motion_if.slave bus
);
  localparam logic [9:0] XS = 10'(X_START);
  localparam logic [9:0] YS = 10'(Y_START);
  localparam logic [9:0] SW = 10'(SPRITE_W);
  localparam logic [9:0] SH = 10'(SPRITE_H);
  localparam logic [10:0] SX = 11'(SCROLL_X);
  localparam logic [10:0] XM = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] YM = 11'(SCREEN_H - SPRITE_H);
  localparam logic [5:0] WV = 6'(WALK_V);
  localparam logic [5:0] JV = 6'(JUMP_V);
  localparam logic [5:0] GV = 6'(GRAVITY);
  localparam logic [5:0] MF = 6'(MAX_FALL_V);
  localparam logic [20:0] LM = 21'(LX_MAX);
  motion_state_t st, st_n;
  logic [9:0] x, x_n, y, y_n;
  logic [5:0] rv, rv_n, lv, lv_n, uv, uv_n, dv, dv_n;
  logic [20:0] lx, lx_n, lx_sum;
  logic [10:0] x_sum, x_dif, y_up, y_dn;
  logic armed, armed_n, tick, jump;
  frame_tick_sync u_sync (.clk(Clk), .rst(Reset), .d(bus.frame_clk), .tick(tick));
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      st <= FALL;
      x <= XS;
      y <= YS;
      rv <= '0;
      lv <= '0;
      uv <= '0;
      dv <= '0;
      lx <= '0;
      armed <= 1'b1;
    end else if (tick) begin
      st <= st_n;
      x <= x_n;
      y <= y_n;
      rv <= rv_n;
      lv <= lv_n;
      uv <= uv_n;
      dv <= dv_n;
      lx <= lx_n;
      armed <= armed_n;
    end
  always_comb begin
    jump = bus.keycode == KEY_JUMP;
    rv_n = (bus.keycode == KEY_RIGHT) ? WV : '0;
    lv_n = (bus.keycode == KEY_LEFT) ? WV : '0;
    x_sum = {1'b0, x} + 11'(rv_n);
    x_dif = {1'b0, x} - 11'(lv_n);
    lx_sum = lx + 21'(x_sum - SX);
    x_n = x;
    lx_n = lx;
    if (bus.rightFlag && rv_n != '0) x_n = bus.collision_right - SW;
    else if (bus.leftFlag && lv_n != '0) x_n = bus.collision_left + 10'd1;
    else if (rv_n != '0 && lx < LM && x_sum > SX) begin
      x_n = SX[9:0];
      lx_n = (lx_sum > LM) ? LM : lx_sum;
    end
    else if (rv_n != '0) x_n = (x_sum > XM) ? XM[9:0] : x_sum[9:0];
    else if (lv_n != '0) x_n = x_dif[10] ? '0 : x_dif[9:0];
    st_n = st;
    y_n = y;
    uv_n = uv;
    dv_n = dv;
    armed_n = armed | ~jump;
    y_up = {1'b0, y} - 11'(uv);
    y_dn = {1'b0, y} + 11'(dv);
    case (st)
      GROUND: begin
        if (jump && armed) begin
          uv_n = JV;
          armed_n = 1'b0;
          st_n = RISE;
        end else if (!bus.downFlag) st_n = FALL;
      end
      RISE: begin
        if (bus.upFlag) begin
          y_n = bus.collision_up + 10'd1;
          uv_n = '0;
          st_n = FALL;
        end else if (y_up[10]) begin
          y_n = '0;
          uv_n = '0;
          st_n = FALL;
        end else begin
          y_n = y_up[9:0];
          uv_n = (uv > GV) ? uv - GV : '0;
          st_n = (uv > GV) ? RISE : FALL;
        end
      end
      default: begin
        if (bus.downFlag) begin
          y_n = bus.collision_down - SH;
          dv_n = '0;
          st_n = GROUND;
        end else if (y_dn > YM) begin
          y_n = YM[9:0];
          dv_n = '0;
          st_n = GROUND;
        end else begin
          y_n = y_dn[9:0];
          dv_n = (dv + GV > MF) ? MF : dv + GV;
        end
      end
    endcase
  end
  assign bus.X_Pos = x;
  assign bus.Y_Pos = y;
  assign bus.Right_V = rv;
  assign bus.Left_V = lv;
  assign bus.Up_V = uv;
  assign bus.Down_V = dv;
  assign bus.logicalX = lx;
  assign bus.grounded = st == GROUND;
endmodule

// File: tb/tb_mario_motion.sv
// tb_mario_motion: directed scenarios plus random frames checked every cycle against an integer model
module tb_mario_motion;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  mario_motion_if bus();
  mario_motion dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  int tests = 0;
  int fails = 0;
  bit run = 1'b0;
  int mx, my, mrv, mlv, muv, mdv, mlx, mst;
  bit marm;
  localparam int S_GROUND = 0, S_RISE = 1, S_FALL = 2;
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic void model_reset();
    mx = 64; my = 400; mrv = 0; mlv = 0; muv = 0; mdv = 0; mlx = 0;
    mst = S_FALL; marm = 1'b1;
  endfunction
  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction
  // One frame of player physics in plain integer arithmetic
  task automatic model_step();
    bit j, uf, df;
    int s;
    j = bus.keycode == 8'h1A;
    uf = bus.upFlag;
    df = bus.downFlag;
    mrv = (bus.keycode == 8'h07) ? 2 : 0;
    mlv = (bus.keycode == 8'h04) ? 2 : 0;
    if (bus.rightFlag && mrv > 0) mx = int'(bus.collision_right) - 16;
    else if (bus.leftFlag && mlv > 0) mx = int'(bus.collision_left) + 1;
    else if (mrv > 0) begin
      s = mx + mrv;
      if (s > 320 && mlx < 2400) begin
        mlx = imin(mlx + s - 320, 2400);
        mx = 320;
      end else mx = imin(s, 624);
    end else if (mlv > 0) mx = (mx < mlv) ? 0 : mx - mlv;
    if (mst == S_GROUND) begin
      if (j && marm) begin muv = 12; marm = 1'b0; mst = S_RISE; end
      else if (!df) mst = S_FALL;
    end else if (mst == S_RISE) begin
      if (uf) begin my = int'(bus.collision_up) + 1; muv = 0; mst = S_FALL; end
      else if (my < muv) begin my = 0; muv = 0; mst = S_FALL; end
      else begin
        my = my - muv;
        muv = (muv > 1) ? muv - 1 : 0;
        if (muv == 0) mst = S_FALL;
      end
    end else begin
      if (df) begin my = int'(bus.collision_down) - 16; mdv = 0; mst = S_GROUND; end
      else if (my + mdv > 464) begin my = 464; mdv = 0; mst = S_GROUND; end
      else begin my = my + mdv; mdv = imin(mdv + 1, 8); end
    end
    if (!j) marm = 1'b1;
  endtask
  always @(negedge Clk) if (run) begin
    chk("X_Pos", int'(bus.X_Pos), mx);
    chk("Y_Pos", int'(bus.Y_Pos), my);
    chk("Right_V", int'(bus.Right_V), mrv);
    chk("Left_V", int'(bus.Left_V), mlv);
    chk("Up_V", int'(bus.Up_V), muv);
    chk("Down_V", int'(bus.Down_V), mdv);
    chk("logicalX", int'(bus.logicalX), mlx);
    chk("grounded", int'(bus.grounded), int'(mst == S_GROUND));
  end
  // Called at a negedge: raise frame_clk, step the model on the update edge, drop frame_clk
  task automatic step(input logic [7:0] k, input logic rf, lf, uf, df,
                      input int cr, cl, cu, cd);
    bus.keycode = k;
    bus.rightFlag = rf;
    bus.leftFlag = lf;
    bus.upFlag = uf;
    bus.downFlag = df;
    bus.collision_right = 10'(cr);
    bus.collision_left = 10'(cl);
    bus.collision_up = 10'(cu);
    bus.collision_down = 10'(cd);
    bus.frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    model_step();
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask
  initial begin
    logic [7:0] k;
    int r;
    bus.frame_clk = 1'b0;
    bus.keycode = '0;
    bus.rightFlag = 1'b0;
    bus.leftFlag = 1'b0;
    bus.upFlag = 1'b0;
    bus.downFlag = 1'b0;
    bus.collision_right = '0;
    bus.collision_left = '0;
    bus.collision_up = '0;
    bus.collision_down = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    run = 1'b1;
    @(negedge Clk);
    chk("reset X", int'(bus.X_Pos), 64);
    chk("reset Y", int'(bus.Y_Pos), 400);
    chk("reset grounded", int'(bus.grounded), 0);
    for (int i = 0; i < 10; i++) step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("freefall Down_V", int'(bus.Down_V), 8);
    chk("freefall Y", int'(bus.Y_Pos), 444);
    step(8'h00, 0, 0, 0, 1, 0, 0, 0, 432);
    chk("landing Y", int'(bus.Y_Pos), 416);
    chk("landing grounded", int'(bus.grounded), 1);
    for (int i = 1; i <= 20; i++) begin
      step(8'h1A, 0, 0, 0, 1, 0, 0, 0, 432);
      if (i == 1) chk("jump Up_V", int'(bus.Up_V), 12);
      if (i == 13) chk("jump apex Y", int'(bus.Y_Pos), 338);
    end
    chk("held jump Up_V", int'(bus.Up_V), 0);
    chk("held jump grounded", int'(bus.grounded), 1);
    step(8'h00, 0, 0, 0, 1, 0, 0, 0, 432);
    step(8'h1A, 0, 0, 0, 1, 0, 0, 0, 432);
    chk("rejump Up_V", int'(bus.Up_V), 12);
    step(8'h1A, 0, 0, 0, 1, 0, 0, 0, 432);
    step(8'h1A, 0, 0, 0, 1, 0, 0, 0, 432);
    chk("rise Up_V", int'(bus.Up_V), 10);
    step(8'h00, 0, 0, 1, 1, 0, 0, 100, 432);
    chk("ceiling Y", int'(bus.Y_Pos), 101);
    chk("ceiling Up_V", int'(bus.Up_V), 0);
    step(8'h00, 0, 0, 0, 1, 0, 0, 0, 432);
    for (int i = 0; i < 127; i++) step(8'h07, 0, 0, 0, 1, 0, 0, 0, 432);
    chk("walk X", int'(bus.X_Pos), 318);
    step(8'h07, 0, 0, 0, 1, 0, 0, 0, 432);
    chk("scroll edge X", int'(bus.X_Pos), 320);
    chk("scroll edge lx", int'(bus.logicalX), 0);
    step(8'h07, 0, 0, 0, 1, 0, 0, 0, 432);
    chk("scroll lx", int'(bus.logicalX), 2);
    for (int i = 0; i < 1199; i++) step(8'h07, 0, 0, 0, 1, 0, 0, 0, 432);
    chk("scroll max lx", int'(bus.logicalX), 2400);
    step(8'h07, 0, 0, 0, 1, 0, 0, 0, 432);
    chk("past scroll X", int'(bus.X_Pos), 322);
    step(8'h07, 1, 0, 0, 1, 200, 0, 0, 432);
    chk("wall X", int'(bus.X_Pos), 184);
    bus.frame_clk = 1'b1;
    @(posedge Clk);
    #2 Reset = 1'b1;
    model_reset();
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    chk("midreset X", int'(bus.X_Pos), 64);
    chk("midreset lx", int'(bus.logicalX), 0);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 6));
      k = (r == 0) ? 8'h04 : (r <= 3) ? 8'h07 : (r == 4) ? 8'h1A :
          (r == 5) ? 8'h00 : 8'($urandom_range(8, 255));
      step(k, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(16, 639)), int'($urandom_range(0, 600)),
           int'($urandom_range(0, 300)), int'($urandom_range(16, 479)));
    end
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
